// File: rtl/vga_crtc_regfile.sv
// Purpose: double-banked VGA CRTC register file; software writes a pending bank, the active bank feeds timing.
// Latency: read/write ack 1 cycle after request; active bank updates 1 edge after vsync rise (or after write when DEFERRED=0).
// Backpressure: none, a request is accepted every cycle and acknowledged exactly once.
//
// Ports:
//   clock_i / reset_ni        : clock, asynchronous active-low reset
//   mem_req_i, mem_write_i    : access request and direction (1 = write)
//   mem_addr_i, mem_bes_ni    : word address, active-low byte enables (lane n -> reg 4*addr+n)
//   mem_data_i / mem_data_o   : write data / registered read data (pending bank)
//   mem_ack_o                 : one-cycle acknowledge
//   vsync_i                   : vertical retrace level, commit on rising edge
//   crtc_regs_o               : active bank, register k at [8k+7:8k]
//   update_o, pending_o       : active bank changed last edge / uncommitted writes exist
module vga_crtc_regfile #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEFERRED   = 1,
    parameter int PROTECT_EN = 1
) (
    input  logic                                clock_i,
    input  logic                                reset_ni,
    input  logic                                mem_req_i,
    input  logic                                mem_write_i,
    input  logic [ADDR_WIDTH-1:0]               mem_addr_i,
    input  logic [3:0]                          mem_bes_ni,
    input  logic [31:0]                         mem_data_i,
    output logic [31:0]                         mem_data_o,
    output logic                                mem_ack_o,
    input  logic                                vsync_i,
    output logic [8*(4<<ADDR_WIDTH)-1:0]        crtc_regs_o,
    output logic                                update_o,
    output logic                                pending_o
);

    localparam int NUM_REGS = 4 << ADDR_WIDTH;
    localparam int IDX_W    = ADDR_WIDTH + 2;
    localparam int CR11     = 17;

    typedef logic [NUM_REGS-1:0][7:0] bank_t;

    bank_t       pend_q, pend_d;
    bank_t       act_q, act_d;
    logic        vsync_q;
    logic        pending_q, pending_d;
    logic        update_q, update_d;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rword;
    logic [3:0]  lane_en;
    logic        wr_any;
    logic        protect;
    logic        commit;
    logic [IDX_W-1:0] idx;
    logic [7:0]  old_val;
    logic [7:0]  new_val;

    assign lane_en = (mem_req_i && mem_write_i) ? ~mem_bes_ni : 4'b0000;
    assign wr_any  = |lane_en;

    // Protect bit comes from the pending bank as it stood before this write.
    generate
        if (PROTECT_EN != 0 && NUM_REGS > CR11) begin : g_prot
            assign protect = pend_q[CR11][7];
        end else begin : g_noprot
            assign protect = 1'b0;
        end
    endgenerate

    // Rising edge of vsync with something to commit.
    assign commit = (DEFERRED != 0) && vsync_i && !vsync_q && pending_q;

    always_comb begin
        pend_d  = pend_q;
        act_d   = act_q;
        idx     = '0;
        old_val = '0;
        new_val = '0;
        // Commit snapshots the pre-write pending bank, so a coincident write stays pending.
        if (commit) begin
            act_d = pend_q;
        end
        for (int n = 0; n < 4; n++) begin
            if (lane_en[n]) begin
                idx     = {mem_addr_i, 2'(n)};
                old_val = pend_q[idx];
                new_val = mem_data_i[8*n +: 8];
                if (protect) begin
                    if (idx < IDX_W'(7)) begin
                        new_val = old_val;
                    end else if (idx == IDX_W'(7)) begin
                        // CR07 stays writable only in bit 4 (line compare bit 8).
                        new_val = {old_val[7:5], mem_data_i[8*n+4], old_val[3:0]};
                    end
                end
                pend_d[idx] = new_val;
                if (DEFERRED == 0) begin
                    act_d[idx] = new_val;
                end
            end
        end
    end

    always_comb begin
        rword = '0;
        for (int n = 0; n < 4; n++) begin
            rword[8*n +: 8] = pend_q[{mem_addr_i, 2'(n)}];
        end
    end

    always_comb begin
        pending_d = 1'b0;
        update_d  = 1'b0;
        if (DEFERRED != 0) begin
            // A write counts as pending even when protection dropped every lane.
            if (wr_any) begin
                pending_d = 1'b1;
            end else if (commit) begin
                pending_d = 1'b0;
            end else begin
                pending_d = pending_q;
            end
            update_d = commit;
        end else begin
            update_d = wr_any;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pend_q    <= '0;
            act_q     <= '0;
            vsync_q   <= 1'b0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pend_q    <= pend_d;
            act_q     <= act_d;
            vsync_q   <= vsync_i;
            pending_q <= pending_d;
            update_q  <= update_d;
            ack_q     <= mem_req_i;
            if (mem_req_i && !mem_write_i) begin
                rdata_q <= rword;
            end
        end
    end

    assign mem_data_o  = rdata_q;
    assign mem_ack_o   = ack_q;
    assign crtc_regs_o = act_q;
    assign update_o    = update_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_vga_crtc_regfile.sv
// Purpose: directed bench for vga_crtc_regfile, deferred and immediate builds side by side.
// Latency: drives after each rising edge, samples 1 ns after the following edge.
// Backpressure: none expected from the design; every request is checked for its ack.
module tb_vga_crtc_regfile;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic         wr;
    logic [2:0]   addr;
    logic [3:0]   bes_n;
    logic [31:0]  wdata;
    logic         vsync;

    logic [31:0]  rdata, rdata0;
    logic         ack, ack0;
    logic         upd, upd0;
    logic         pend, pend0;
    logic [255:0] regs, regs0;
    logic [255:0] exp_regs;

    int checks = 0;
    int errors = 0;
    int upd_cnt;

    always #5 clk = ~clk;

    vga_crtc_regfile #(.ADDR_WIDTH(3), .DEFERRED(1), .PROTECT_EN(1)) dut (
        .clock_i(clk), .reset_ni(rst_n),
        .mem_req_i(req), .mem_write_i(wr), .mem_addr_i(addr), .mem_bes_ni(bes_n),
        .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack),
        .vsync_i(vsync), .crtc_regs_o(regs), .update_o(upd), .pending_o(pend)
    );

    vga_crtc_regfile #(.ADDR_WIDTH(3), .DEFERRED(0), .PROTECT_EN(1)) dut0 (
        .clock_i(clk), .reset_ni(rst_n),
        .mem_req_i(req), .mem_write_i(wr), .mem_addr_i(addr), .mem_bes_ni(bes_n),
        .mem_data_i(wdata), .mem_data_o(rdata0), .mem_ack_o(ack0),
        .vsync_i(vsync), .crtc_regs_o(regs0), .update_o(upd0), .pending_o(pend0)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; caller decides whether the next cycle is idle.
    task automatic bus(input logic w, input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        req   = 1'b1;
        wr    = w;
        addr  = a;
        bes_n = be;
        wdata = d;
        step();
    endtask

    task automatic idle();
        req   = 1'b0;
        wr    = 1'b0;
        bes_n = 4'hF;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; bes_n = 4'hF; wdata = '0; vsync = 1'b0;
        #12;
        check("rst_regs", regs, '0);
        check("rst_ack", ack, 1'b0);
        check("rst_rdata", rdata, '0);
        check("rst_update", upd, 1'b0);
        check("rst_pending", pend, 1'b0);
        #10 rst_n = 1'b1;
        step();

        // Basic read after reset
        bus(1'b0, 3'd0, 4'hF, '0);
        check("rd0_ack", ack, 1'b1);
        check("rd0_data", rdata, 32'h0);
        check("rd0_regs", regs, '0);
        idle();
        check("ack_one_cycle", ack, 1'b0);

        // Partial-lane write, then back-to-back reads
        bus(1'b1, 3'd1, 4'b1010, 32'hA1B2C3D4);
        check("wr_ack", ack, 1'b1);
        bus(1'b0, 3'd1, 4'hF, '0);
        check("rd1_data", rdata, 32'h00B200D4);
        check("rd1_pending", pend, 1'b1);
        bus(1'b0, 3'd0, 4'hF, '0);
        check("b2b_ack", ack, 1'b1);
        check("b2b_rd0", rdata, 32'h0);
        idle();
        repeat (3) step();
        check("active_held", regs, '0);
        check("no_update_idle", upd, 1'b0);

        vsync = 1'b1;
        step();
        exp_regs = '0;
        exp_regs[39:32] = 8'hD4;
        exp_regs[55:48] = 8'hB2;
        check("commit_regs", regs, exp_regs);
        check("commit_update", upd, 1'b1);
        vsync = 1'b0;
        step();
        check("update_pulse_end", upd, 1'b0);
        check("pending_cleared", pend, 1'b0);

        // Write protect: fresh reset, set CR11[7], commit
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
        bus(1'b1, 3'd4, 4'b1101, 32'h0000_8000);
        idle();
        vsync = 1'b1;
        step();
        exp_regs = '0;
        exp_regs[143:136] = 8'h80;
        check("cr11_commit", regs, exp_regs);
        vsync = 1'b0;
        step();
        bus(1'b1, 3'd0, 4'b0000, 32'hFFFFFFFF);
        bus(1'b1, 3'd1, 4'b0000, 32'hFFFFFFFF);
        idle();
        check("prot_pending", pend, 1'b1);
        bus(1'b0, 3'd0, 4'hF, '0);
        check("prot_rd0", rdata, 32'h00000000);
        bus(1'b0, 3'd1, 4'hF, '0);
        check("prot_rd1", rdata, 32'h10000000);
        bus(1'b1, 3'd2, 4'b0000, 32'hDEADBEEF);
        check("wr_keeps_rdata", rdata, 32'h10000000);
        bus(1'b1, 3'd4, 4'b1101, 32'h0);
        bus(1'b1, 3'd0, 4'b0000, 32'hFFFFFFFF);
        bus(1'b0, 3'd0, 4'hF, '0);
        check("unprot_rd0", rdata, 32'hFFFFFFFF);
        bus(1'b0, 3'd2, 4'hF, '0);
        check("rd2_unprot", rdata, 32'hDEADBEEF);
        idle();

        // Write coinciding with vsync rise
        bus(1'b1, 3'd0, 4'b0000, 32'hAAAAAAAA);
        vsync = 1'b1;
        bus(1'b1, 3'd0, 4'b0000, 32'h11223344);
        check("same_cyc_old", regs[31:0], 32'hAAAAAAAA);
        check("same_cyc_update", upd, 1'b1);
        check("same_cyc_pending", pend, 1'b1);
        req = 1'b0; wr = 1'b0; bes_n = 4'hF;
        upd_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (upd) upd_cnt++;
        end
        check("held_vsync_updates", upd_cnt, 0);
        check("held_vsync_regs", regs[31:0], 32'hAAAAAAAA);
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        step();
        check("second_commit", regs[31:0], 32'h11223344);
        check("second_update", upd, 1'b1);
        check("second_pending", pend, 1'b0);
        vsync = 1'b0;
        step();

        // Asynchronous reset with a write pending and its ack in flight
        bus(1'b1, 3'd2, 4'b0000, 32'hCAFEF00D);
        req = 1'b0; wr = 1'b0; bes_n = 4'hF;
        check("pre_rst_ack", ack, 1'b1);
        check("pre_rst_pending", pend, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_ack", ack, 1'b0);
        check("async_pending", pend, 1'b0);
        check("async_regs", regs, '0);
        check("async_rdata", rdata, '0);
        #2 rst_n = 1'b1;
        step();
        vsync = 1'b1;
        step();
        check("post_rst_no_update", upd, 1'b0);
        check("post_rst_regs", regs, '0);
        vsync = 1'b0;
        step();
        bus(1'b0, 3'd2, 4'hF, '0);
        check("post_rst_discard", rdata, 32'h0);

        // Immediate build: write reaches the active bank next edge
        bus(1'b1, 3'd0, 4'b1110, 32'h0000005F);
        check("imm_regs", regs0[7:0], 8'h5F);
        check("imm_update", upd0, 1'b1);
        check("imm_pending", pend0, 1'b0);
        check("def_regs_untouched", regs[7:0], 8'h00);
        idle();
        check("imm_update_end", upd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
